// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the ALU request arbiter: opcode mnemonics, legality
// check and the response-slot state encoding.
package alu_req_arbiter_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    kADD = 4'd0,
    kXOR = 4'd1,
    kORR = 4'd2,
    kBEQ = 4'd3,
    kBNE = 4'd4,
    kSLL = 4'd5,
    kSRL = 4'd6,
    kXXR = 4'd7,
    kSUB = 4'd8,
    kAND = 4'd9
  } op_mne;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_st_t;

  function automatic logic is_legal_op(input op_mne op);
    case (op)
      kADD, kXOR, kORR, kBEQ, kBNE,
      kSLL, kSRL, kXXR, kSUB, kAND: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_req_arbiter_rr.sv
// Round-robin arbiter: grants the first asserted request at or after the
// priority pointer, wrapping around; the pointer moves past each grant.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx
);

  logic [IW-1:0] r_ptr;
  logic [N-1:0]  w_mask_req;
  logic [N-1:0]  w_pick;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    w_mask_req = '0;
    for (int i = 0; i < N; i++) begin
      w_mask_req[i] = i_req[i] && (IW'(i) >= r_ptr);
    end
    // Requests at or above the pointer win; otherwise wrap to the lowest index.
    w_pick      = (|w_mask_req) ? w_mask_req : i_req;
    o_grant     = '0;
    o_grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_pick[i]) begin
        o_grant     = '0;
        o_grant[i]  = 1'b1;
        o_grant_idx = IW'(i);
      end
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && (|i_req)) begin
      r_ptr <= (o_grant_idx == IW'(N - 1)) ? '0 : o_grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between NREQ requesters: round-robin grant,
// operand mux, and a one-entry registered response slot with backpressure.
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter  int W    = 8,
  parameter  int Ops  = 4,
  parameter  int NREQ = 3,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [NREQ-1:0]     ReqValid,
  output logic [NREQ-1:0]     ReqReady,
  input  logic [NREQ*W-1:0]   ReqA,
  input  logic [NREQ*W-1:0]   ReqB,
  input  logic [NREQ*Ops-1:0] ReqOp,
  output logic [W-1:0]        AluA,
  output logic [W-1:0]        AluB,
  output logic [Ops-1:0]      AluOp,
  input  logic [W-1:0]        AluOut,
  input  logic                AluJump,
  output logic                RspValid,
  input  logic                RspReady,
  output logic [W-1:0]        RspData,
  output logic                RspJump,
  output logic [IDW-1:0]      RspId,
  output logic                RspErr
);

  slot_st_t         r_state;
  logic [W-1:0]     r_data;
  logic             r_jump;
  logic [IDW-1:0]   r_id;
  logic             r_err;

  logic             w_can_issue;
  logic [NREQ-1:0]  w_req;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_grant_idx;
  logic             w_any_grant;
  logic [OP_W-1:0]  w_op_low;
  logic             w_op_hi_zero;
  logic             w_op_legal;

  // Reset gating keeps ReqReady low while Reset_n is asserted.
  assign w_can_issue = Reset_n && ((r_state == EMPTY) || RspReady);
  assign w_req       = ReqValid & {NREQ{w_can_issue}};
  assign w_any_grant = |w_grant;
  assign ReqReady    = w_grant;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk         (Clk),
    .rst_n       (Reset_n),
    .i_req       (w_req),
    .i_advance   (w_can_issue),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  always_comb begin
    AluA  = '0;
    AluB  = '0;
    AluOp = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        AluA  = ReqA[i*W +: W];
        AluB  = ReqB[i*W +: W];
        AluOp = ReqOp[i*Ops +: Ops];
      end
    end
  end

  // Map the opcode field onto the mnemonic width; extra high bits must be zero.
  generate
    if (Ops > OP_W) begin : g_op_wide
      assign w_op_low     = AluOp[OP_W-1:0];
      assign w_op_hi_zero = ~|AluOp[Ops-1:OP_W];
    end else if (Ops == OP_W) begin : g_op_eq
      assign w_op_low     = AluOp;
      assign w_op_hi_zero = 1'b1;
    end else begin : g_op_narrow
      assign w_op_low     = {{(OP_W - Ops){1'b0}}, AluOp};
      assign w_op_hi_zero = 1'b1;
    end
  endgenerate

  assign w_op_legal = w_op_hi_zero && is_legal_op(op_mne'(w_op_low));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_jump  <= 1'b0;
      r_id    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_any_grant) begin
            r_state <= FULL;
            r_data  <= w_op_legal ? AluOut  : '0;
            r_jump  <= w_op_legal ? AluJump : 1'b0;
            r_id    <= w_grant_idx;
            r_err   <= ~w_op_legal;
          end
        end
        FULL: begin
          if (RspReady) begin
            if (w_any_grant) begin
              r_data <= w_op_legal ? AluOut  : '0;
              r_jump <= w_op_legal ? AluJump : 1'b0;
              r_id   <= w_grant_idx;
              r_err  <= ~w_op_legal;
            end else begin
              r_state <= EMPTY;
            end
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign RspValid = (r_state == FULL);
  assign RspData  = r_data;
  assign RspJump  = r_jump;
  assign RspId    = r_id;
  assign RspErr   = r_err;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed scoreboard bench for alu_req_arbiter with a behavioural ALU that
// drives X for illegal opcodes.
module tb_alu_req_arbiter;
  import alu_req_arbiter_pkg::*;

  localparam int W    = 8;
  localparam int OPS  = 4;
  localparam int NREQ = 3;
  localparam int IDW  = 2;

  typedef struct {
    logic [W-1:0]   data;
    logic           jump;
    logic [IDW-1:0] id;
    logic           err;
  } rsp_t;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ*OPS-1:0] req_op;
  logic [W-1:0]        alu_a;
  logic [W-1:0]        alu_b;
  logic [OPS-1:0]      alu_op;
  logic [W-1:0]        alu_out;
  logic                alu_jump;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [W-1:0]        rsp_data;
  logic                rsp_jump;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_err;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_req_arbiter #(.W(W), .Ops(OPS), .NREQ(NREQ)) dut (
    .Clk      (clk),
    .Reset_n  (rst_n),
    .ReqValid (req_valid),
    .ReqReady (req_ready),
    .ReqA     (req_a),
    .ReqB     (req_b),
    .ReqOp    (req_op),
    .AluA     (alu_a),
    .AluB     (alu_b),
    .AluOp    (alu_op),
    .AluOut   (alu_out),
    .AluJump  (alu_jump),
    .RspValid (rsp_valid),
    .RspReady (rsp_ready),
    .RspData  (rsp_data),
    .RspJump  (rsp_jump),
    .RspId    (rsp_id),
    .RspErr   (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU standing in for the parent's instance.
  always_comb begin
    alu_out  = '0;
    alu_jump = 1'b0;
    case (alu_op)
      kADD: alu_out = alu_a + alu_b;
      kXOR: alu_out = alu_a ^ alu_b;
      kORR: alu_out = alu_a | alu_b;
      kBEQ: begin alu_jump = (alu_a == alu_b); alu_out = {7'd0, alu_jump}; end
      kBNE: begin alu_jump = (alu_a != alu_b); alu_out = {7'd0, alu_jump}; end
      kSLL: alu_out = alu_a << alu_b[2:0];
      kSRL: alu_out = alu_a >> alu_b[2:0];
      kXXR: alu_out = ~(alu_a ^ alu_b);
      kSUB: alu_out = alu_a - alu_b;
      kAND: alu_out = alu_a & alu_b;
      default: begin alu_out = 'x; alu_jump = 1'bx; end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [OPS-1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_op[i*OPS +: OPS] = op;
    req_a[i*W +: W]      = a;
    req_b[i*W +: W]      = b;
  endtask

  task automatic expect_rsp(input logic [W-1:0] d, input logic j, input logic [IDW-1:0] id,
                            input logic e);
    rsp_t r;
    r.data = d;
    r.jump = j;
    r.id   = id;
    r.err  = e;
    sb.push_back(r);
  endtask

  // Monitor: a response is consumed on the edge after a valid&ready negedge sample.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id=%0h data=%0h with no pending expectation",
                 rsp_id, rsp_data);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_jump", rsp_jump, e.jump);
        check("rsp_id",   rsp_id,   e.id);
        check("rsp_err",  rsp_err,  e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] exp_grant [4];
    logic [W-1:0]    exp_data  [4];
    logic [IDW-1:0]  exp_id    [4];
    exp_grant = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_data  = '{8'h1E, 8'h2A, 8'hFF, 8'h1E};
    exp_id    = '{2'd0, 2'd1, 2'd2, 2'd0};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    set_req(0, kADD, 8'h05, 8'h03);
    req_valid = 3'b001;
    repeat (2) cyc();

    at_neg();
    check("reset_valid", rsp_valid, 1'b0);
    check("reset_data",  rsp_data,  8'h00);
    check("reset_jump",  rsp_jump,  1'b0);
    check("reset_id",    rsp_id,    2'd0);
    check("reset_err",   rsp_err,   1'b0);
    check("reset_ready", req_ready, 3'b000);

    // Single ADD from requester 0.
    cyc();
    rst_n = 1'b1;
    expect_rsp(8'h08, 1'b0, 2'd0, 1'b0);
    at_neg();
    check("add_ready", req_ready, 3'b001);
    check("add_alu_a", alu_a, 8'h05);
    check("add_alu_b", alu_b, 8'h03);
    cyc();
    req_valid = '0;
    at_neg();
    check("add_rsp_valid", rsp_valid, 1'b1);
    check("idle_alu_op",   alu_op, 4'h0);

    // Branch compare from requester 1.
    cyc();
    set_req(1, kBEQ, 8'h2A, 8'h2A);
    req_valid = 3'b010;
    expect_rsp(8'h01, 1'b1, 2'd1, 1'b0);
    at_neg();
    check("beq_ready", req_ready, 3'b010);
    cyc();
    set_req(1, kBNE, 8'h2A, 8'h2A);
    expect_rsp(8'h00, 1'b0, 2'd1, 1'b0);
    at_neg();
    check("bne_ready", req_ready, 3'b010);

    // Illegal opcode from requester 2.
    cyc();
    req_valid = 3'b100;
    set_req(2, 4'hC, 8'h11, 8'h22);
    expect_rsp(8'h00, 1'b0, 2'd2, 1'b1);
    at_neg();
    check("ill_ready", req_ready, 3'b100);
    check("ill_alu_known", $isunknown({alu_a, alu_b, alu_op, req_ready}), 1'b0);
    cyc();
    req_valid = '0;
    at_neg();
    check("ill_rsp_err", rsp_err, 1'b1);
    check("ill_no_x", $isunknown({rsp_valid, rsp_data, rsp_jump, rsp_id, rsp_err}), 1'b0);

    // Round robin across all three with full throughput.
    cyc();
    set_req(0, kADD, 8'h10, 8'h0E);
    set_req(1, kSUB, 8'h32, 8'h08);
    set_req(2, kXOR, 8'hF0, 8'h0F);
    req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      expect_rsp(exp_data[k], 1'b0, exp_id[k], 1'b0);
      at_neg();
      check("rr_grant", req_ready, exp_grant[k]);
    end

    // Backpressure: slot FULL with the last id0 result, consumer stalls.
    cyc();
    req_valid = 3'b011;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      at_neg();
      check("stall_ready", req_ready, 3'b000);
      check("stall_valid", rsp_valid, 1'b1);
      check("stall_data",  rsp_data,  8'h1E);
      check("stall_id",    rsp_id,    2'd0);
    end
    cyc();
    rsp_ready = 1'b1;
    expect_rsp(8'h2A, 1'b0, 2'd1, 1'b0);
    at_neg();
    check("drain_grant", req_ready, 3'b010);
    cyc();
    req_valid = '0;
    at_neg();
    check("drain_next_valid", rsp_valid, 1'b1);
    check("drain_next_id",    rsp_id,    2'd1);

    // Reset in the middle of a burst while the slot is FULL.
    cyc();
    req_valid = 3'b111;
    expect_rsp(8'hFF, 1'b0, 2'd2, 1'b0);
    at_neg();
    check("burst_grant0", req_ready, 3'b100);
    cyc();
    expect_rsp(8'h1E, 1'b0, 2'd0, 1'b0);
    at_neg();
    check("burst_grant1", req_ready, 3'b001);
    cyc();
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rst_async_valid", rsp_valid, 1'b0);
    check("rst_async_ready", req_ready, 3'b000);
    repeat (2) cyc();
    rst_n = 1'b1;
    expect_rsp(8'h1E, 1'b0, 2'd0, 1'b0);
    at_neg();
    check("post_rst_grant", req_ready, 3'b001);
    cyc();
    req_valid = '0;
    at_neg();
    check("post_rst_valid", rsp_valid, 1'b1);
    check("post_rst_id",    rsp_id,    2'd0);
    repeat (3) cyc();
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
